s2p: RTL and testbench

- Input deserializer of the SM4.0 datapath; sits directly upstream of the SM4 round core, which in turn feeds the p2s output stage.
- Accepts a serial stream of IO_WIDTH-bit packets, each {val, eop, data}, and assembles them MSB-first into BLOCK_LENGTH-bit blocks tagged with an end-of-packet bit.
- Presents each block to the core with a valid/stall handshake and back-pressures the source through hold_i.

---
 rtl/s2p_pkg.sv | 21 ++
 rtl/s2p.sv | 92 +++++++++
 tb/tb_s2p.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/s2p_pkg.sv
// Shared constants and types for the s2p input deserializer.
// Packet field indices are also used by the p2s output stage.
package s2p_pkg;

   localparam int BLOCK_LENGTH = 128;
   localparam int IO_WIDTH     = 8;
   localparam int ITER_NUM     = BLOCK_LENGTH / IO_WIDTH;
   localparam int COUNT_WIDTH  = $clog2(ITER_NUM);

   // Packet layout: {val, eop, data}
   localparam int VAL_BIT = IO_WIDTH + 1;
   localparam int EOP_BIT = IO_WIDTH;
   localparam int PKT_WIDTH = IO_WIDTH + 2;

   // ACCUM: block register empty; PEND: block register holds an unconsumed block.
   typedef enum logic {
      ACCUM = 1'b0,
      PEND  = 1'b1
   } s2p_state_e;

endpackage : s2p_pkg

// File: rtl/s2p.sv
// Serial-to-parallel deserializer: packs IO_WIDTH beats MSB-first into a
// BLOCK_LENGTH block tagged with eop, offered with a valid/stall handshake.
module s2p
   import s2p_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [PKT_WIDTH-1:0]    d_in,
   input  logic                    stall,
   output logic                    hold_i,
   output logic                    block_valid,
   output logic [BLOCK_LENGTH:0]   block,
   output logic                    busy,
   output logic                    err_len,
   output s2p_state_e              state_o
);

   // Handshake: a block transfers on an edge where block_valid && !stall.
   // While a block waits under stall, hold_i tells the source to freeze.

   s2p_state_e              state_q, state_d;
   logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [BLOCK_LENGTH-1:0] buf_q, buf_d;
   logic [BLOCK_LENGTH:0]   block_q, block_d;
   logic                    err_q, err_d;

   logic                    in_val, in_eop;
   logic [IO_WIDTH-1:0]     in_data;
   logic                    accept, last_beat, complete;
   logic [BLOCK_LENGTH-1:0] beat_pos, merged;

   assign in_val  = d_in[VAL_BIT];
   assign in_eop  = d_in[EOP_BIT];
   assign in_data = d_in[IO_WIDTH-1:0];

   assign block_valid = (state_q == PEND);
   assign hold_i      = block_valid && stall;
   assign accept      = in_val && !hold_i;
   assign last_beat   = (cnt_q == COUNT_WIDTH'(ITER_NUM - 1));
   assign complete    = accept && (last_beat || in_eop);

   // Unwritten slices of buf_q are always zero, so OR places the beat.
   always_comb begin
      beat_pos = {in_data, {(BLOCK_LENGTH-IO_WIDTH){1'b0}}} >> (int'(cnt_q) * IO_WIDTH);
      merged   = buf_q | beat_pos;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      block_d = block_q;
      err_d   = 1'b0;
      if (complete) begin
         block_d = {merged, in_eop};
         state_d = PEND;
         cnt_d   = '0;
         buf_d   = '0;
         err_d   = in_eop && !last_beat;
      end else begin
         if (accept) begin
            buf_d = merged;
            cnt_d = cnt_q + 1'b1;
         end
         if (block_valid && !stall) begin
            state_d = ACCUM;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         cnt_q   <= '0;
         buf_q   <= '0;
         block_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         block_q <= block_d;
         err_q   <= err_d;
      end
   end

   assign block   = block_q;
   assign busy    = (cnt_q != '0);
   assign err_len = err_q;
   assign state_o = state_q;

endmodule : s2p

// File: tb/tb_s2p.sv
// Directed self-checking bench for s2p: full blocks, back-to-back loads,
// stall/hold, early eop, idle beats and mid-block reset.
module tb_s2p;
   import s2p_pkg::*;

   logic                  clk;
   logic                  rst_n;
   logic [PKT_WIDTH-1:0]  d_in;
   logic                  stall;
   logic                  hold_i;
   logic                  block_valid;
   logic [BLOCK_LENGTH:0] block;
   logic                  busy;
   logic                  err_len;
   s2p_state_e            state_o;

   int vectors;
   int miscompares;

   s2p dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .d_in        (d_in),
      .stall       (stall),
      .hold_i      (hold_i),
      .block_valid (block_valid),
      .block       (block),
      .busy        (busy),
      .err_len     (err_len),
      .state_o     (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one packet for one cycle; returns 1 time unit after the edge.
   task automatic beat(input logic v, input logic e, input logic [IO_WIDTH-1:0] dat);
      d_in = {v, e, dat};
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      stall = 1'b0;
      d_in  = '0;
      #1;
      vectors++; if (block_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", block_valid); miscompares++; end
      vectors++; if (block !== '0) begin $display("FAIL reset_block got %h want 0", block); miscompares++; end
      vectors++; if ({hold_i, busy, err_len} !== 3'b000) begin $display("FAIL reset_flags got %b want 000", {hold_i, busy, err_len}); miscompares++; end
      vectors++; if (state_o !== ACCUM) begin $display("FAIL reset_state got %0d want ACCUM", state_o); miscompares++; end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_full_block();
      for (int i = 0; i < 16; i++) begin
         beat(1'b1, (i == 15), 8'(i));
         if (i == 14) begin
            vectors++; if (busy !== 1'b1) begin $display("FAIL full_busy got %b want 1", busy); miscompares++; end
         end
      end
      vectors++; if (block_valid !== 1'b1) begin $display("FAIL full_valid got %b want 1", block_valid); miscompares++; end
      vectors++; if (block[128:1] !== 128'h000102030405060708090a0b0c0d0e0f) begin $display("FAIL full_data got %h want 000102030405060708090a0b0c0d0e0f", block[128:1]); miscompares++; end
      vectors++; if ({block[0], err_len, busy} !== 3'b100) begin $display("FAIL full_eop_err_busy got %b want 100", {block[0], err_len, busy}); miscompares++; end
      vectors++; if (state_o !== PEND) begin $display("FAIL full_state got %0d want PEND", state_o); miscompares++; end
      beat(1'b0, 1'b0, 8'h00);
      vectors++; if (block_valid !== 1'b0) begin $display("FAIL full_consume got %b want 0", block_valid); miscompares++; end
   endtask

   task automatic test_stream_32();
      for (int i = 0; i < 32; i++) begin
         beat(1'b1, 1'b0, 8'(8'h10 + i));
         if (i == 15) begin
            vectors++; if (block !== {128'h101112131415161718191a1b1c1d1e1f, 1'b0}) begin $display("FAIL stream_blk1 got %h want 101112131415161718191a1b1c1d1e1f_0", block); miscompares++; end
         end
         if (i == 16) begin
            vectors++; if (block_valid !== 1'b0) begin $display("FAIL stream_consume got %b want 0", block_valid); miscompares++; end
         end
         if (i == 30) begin
            vectors++; if ({block_valid, busy} !== 2'b01) begin $display("FAIL stream_pre_blk2 got %b want 01", {block_valid, busy}); miscompares++; end
         end
      end
      vectors++; if (block_valid !== 1'b1) begin $display("FAIL stream_valid2 got %b want 1", block_valid); miscompares++; end
      vectors++; if (block !== {128'h202122232425262728292a2b2c2d2e2f, 1'b0}) begin $display("FAIL stream_blk2 got %h want 202122232425262728292a2b2c2d2e2f_0", block); miscompares++; end
      beat(1'b0, 1'b0, 8'h00);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) beat(1'b1, 1'b0, 8'(8'h40 + i));
      vectors++; if (block !== {128'h404142434445464748494a4b4c4d4e4f, 1'b0}) begin $display("FAIL b2b_blk1 got %h want 404142434445464748494a4b4c4d4e4f_0", block); miscompares++; end
      // Consume and a one-beat eop packet completing on the same edge.
      beat(1'b1, 1'b1, 8'h99);
      vectors++; if (block_valid !== 1'b1) begin $display("FAIL b2b_no_bubble got %b want 1", block_valid); miscompares++; end
      vectors++; if (block !== {128'h99000000000000000000000000000000, 1'b1}) begin $display("FAIL b2b_blk2 got %h want 99000000000000000000000000000000_1", block); miscompares++; end
      vectors++; if (err_len !== 1'b1) begin $display("FAIL b2b_err got %b want 1", err_len); miscompares++; end
      beat(1'b0, 1'b0, 8'h00);
      vectors++; if ({block_valid, err_len} !== 2'b00) begin $display("FAIL b2b_drain got %b want 00", {block_valid, err_len}); miscompares++; end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 16; i++) begin
         if (i == 15) stall = 1'b1;
         beat(1'b1, 1'b0, 8'hAA);
      end
      for (int i = 0; i < 5; i++) begin
         d_in = {1'b1, 1'b0, 8'h55};
         #1;
         vectors++; if (hold_i !== 1'b1) begin $display("FAIL stall_hold cyc %0d got %b want 1", i, hold_i); miscompares++; end
         @(posedge clk);
         #1;
         vectors++; if ({block_valid, busy} !== 2'b10) begin $display("FAIL stall_freeze cyc %0d got %b want 10", i, {block_valid, busy}); miscompares++; end
         vectors++; if (block !== {{16{8'hAA}}, 1'b0}) begin $display("FAIL stall_block cyc %0d got %h want aa..aa_0", i, block); miscompares++; end
      end
      stall = 1'b0;
      d_in  = '0;
      #1;
      vectors++; if (hold_i !== 1'b0) begin $display("FAIL stall_release_hold got %b want 0", hold_i); miscompares++; end
      @(posedge clk);
      #1;
      vectors++; if ({block_valid, busy} !== 2'b00) begin $display("FAIL stall_transfer got %b want 00", {block_valid, busy}); miscompares++; end
   endtask

   task automatic test_early_eop();
      for (int i = 1; i <= 4; i++) beat(1'b1, 1'b0, 8'(i));
      vectors++; if ({busy, err_len, block_valid} !== 3'b100) begin $display("FAIL early_partial got %b want 100", {busy, err_len, block_valid}); miscompares++; end
      beat(1'b1, 1'b1, 8'h05);
      vectors++; if (block !== {128'h01020304050000000000000000000000, 1'b1}) begin $display("FAIL early_block got %h want 01020304050000000000000000000000_1", block); miscompares++; end
      vectors++; if ({block_valid, err_len, busy} !== 3'b110) begin $display("FAIL early_flags got %b want 110", {block_valid, err_len, busy}); miscompares++; end
      beat(1'b0, 1'b0, 8'h00);
      vectors++; if ({block_valid, err_len} !== 2'b00) begin $display("FAIL early_pulse got %b want 00", {block_valid, err_len}); miscompares++; end
   endtask

   task automatic test_idle_beats();
      for (int i = 0; i < 16; i++) begin
         beat(1'b1, 1'b0, 8'(8'h50 + i));
         if (i == 15) begin
            vectors++; if (block !== {128'h505152535455565758595a5b5c5d5e5f, 1'b0}) begin $display("FAIL idle_block got %h want 505152535455565758595a5b5c5d5e5f_0", block); miscompares++; end
         end
         beat(1'b0, 1'b1, 8'hFF);
         if (i == 7) begin
            vectors++; if ({err_len, block_valid, busy} !== 3'b001) begin $display("FAIL idle_ignored got %b want 001", {err_len, block_valid, busy}); miscompares++; end
         end
      end
      vectors++; if ({block_valid, busy, err_len} !== 3'b000) begin $display("FAIL idle_end got %b want 000", {block_valid, busy, err_len}); miscompares++; end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 7; i++) beat(1'b1, 1'b0, 8'h77);
      vectors++; if (busy !== 1'b1) begin $display("FAIL mreset_busy_before got %b want 1", busy); miscompares++; end
      rst_n = 1'b0;
      #1;
      vectors++; if ({block_valid, busy, hold_i, err_len} !== 4'b0000) begin $display("FAIL mreset_flags got %b want 0000", {block_valid, busy, hold_i, err_len}); miscompares++; end
      vectors++; if (block !== '0) begin $display("FAIL mreset_block got %h want 0", block); miscompares++; end
      d_in = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 16; i++) beat(1'b1, 1'b0, 8'(8'h30 + i));
      vectors++; if (block !== {128'h303132333435363738393a3b3c3d3e3f, 1'b0}) begin $display("FAIL mreset_block2 got %h want 303132333435363738393a3b3c3d3e3f_0", block); miscompares++; end
      vectors++; if (block_valid !== 1'b1) begin $display("FAIL mreset_valid got %b want 1", block_valid); miscompares++; end
      beat(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_full_block();
      test_stream_32();
      test_back_to_back();
      test_stall();
      test_early_eop();
      test_idle_beats();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_s2p
